ifetch_queue: RTL

Instruction prefetch queue sitting directly upstream of the pipelined CPU's fetch port. It issues sequential word fetches to instruction memory, buffers the returned instructions in order with their PCs, and presents them to the CPU under a valid/ready handshake. The CPU's redirect (taken branch, `j`, `jal`, `jr`) flushes the queue and discards in-flight responses. An empty queue drives a NOP (all-zero word).

---
 rtl/ifetch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches under a credit limit,
// buffers in-order responses with their PCs and hands them to the CPU; redirect flushes.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        i_valid,
  input  logic        i_ready,
  output logic [31:0] i_datain,
  output logic [31:0] i_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count, r_inflight, r_discard;
  logic [31:0]     r_fetch_pc, r_resp_pc;

  logic [AW-1:0]   w_head_nxt, w_tail_nxt;
  logic [CW-1:0]   w_count_nxt, w_inflight_nxt, w_discard_nxt;
  logic [31:0]     w_fetch_pc_nxt, w_resp_pc_nxt;
  logic [SW-1:0]   w_credits;
  logic [31:0]     w_redirect_al;
  logic            w_issue, w_drop, w_live, w_push, w_pop;

  assign w_redirect_al = redirect_pc & ~32'h0000_0003;
  assign w_credits     = SW'(r_count) + SW'(r_inflight) + SW'(r_discard);
  assign w_issue       = start && !redirect && (w_credits < SW'(DEPTH));
  // A response is either owed to a pre-redirect request or matches a live one; otherwise it is stray.
  assign w_drop        = imem_rvalid && (r_discard != '0);
  assign w_live        = imem_rvalid && (r_discard == '0) && (r_inflight != '0);
  assign w_push        = w_live && !redirect;
  assign w_pop         = (r_count != '0) && i_ready && !redirect;

  // Next-state for pointers, counters and PCs.
  always_comb begin
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_count_nxt    = r_count;
    w_inflight_nxt = r_inflight;
    w_discard_nxt  = r_discard;
    w_fetch_pc_nxt = r_fetch_pc;
    w_resp_pc_nxt  = r_resp_pc;
    if (redirect) begin
      w_head_nxt     = '0;
      w_tail_nxt     = '0;
      w_count_nxt    = '0;
      w_inflight_nxt = '0;
      w_discard_nxt  = CW'(r_discard + r_inflight - CW'(w_drop || w_live));
      w_fetch_pc_nxt = w_redirect_al;
      w_resp_pc_nxt  = w_redirect_al;
    end else begin
      if (w_issue) begin
        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
      end
      if (w_drop) begin
        w_discard_nxt = r_discard - CW'(1);
      end
      if (w_push) begin
        w_resp_pc_nxt = r_resp_pc + 32'd4;
        w_tail_nxt    = r_tail + AW'(1);
      end
      if (w_pop) begin
        w_head_nxt = r_head + AW'(1);
      end
      w_inflight_nxt = CW'(r_inflight + CW'(w_issue) - CW'(w_push));
      w_count_nxt    = CW'(r_count + CW'(w_push) - CW'(w_pop));
    end
  end

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_inflight <= w_inflight_nxt;
      r_discard  <= w_discard_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_resp_pc  <= w_resp_pc_nxt;
    end
  end

  // Entry storage needs no reset: reads are masked by count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_tail] <= '{pc: r_resp_pc, instr: imem_rdata};
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_fetch_pc;
  assign i_valid   = (r_count != '0);
  assign i_datain  = i_valid ? r_mem[r_head].instr : 32'h0000_0000;
  assign i_pc      = i_valid ? r_mem[r_head].pc : r_resp_pc;

endmodule
